// File: rtl/controlador_preparacao_pkg.sv
// controlador_preparacao_pkg: state codes, drink types and default timing constants
package controlador_preparacao_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VERIFICA = 3'd1,
        AQUECE   = 3'd2,
        EXTRAI   = 3'd3,
        CONCLUI  = 3'd4,
        ERRO     = 3'd5
    } estado_t;

    localparam logic [1:0] TIPO_CURTO  = 2'b00;
    localparam logic [1:0] TIPO_NORMAL = 2'b01;
    localparam logic [1:0] TIPO_LONGO  = 2'b10;
    localparam logic [1:0] TIPO_AGUA   = 2'b11;

    localparam int TEMPO_AQUECE_PADRAO = 3;
    localparam int DOSE_CURTO_PADRAO   = 2;
    localparam int DOSE_NORMAL_PADRAO  = 4;
    localparam int DOSE_LONGO_PADRAO   = 6;
    localparam int DOSE_AGUA_PADRAO    = 8;

    function automatic logic [3:0] seleciona_dose(
        input logic [1:0] tipo,
        input logic [3:0] curto,
        input logic [3:0] normal,
        input logic [3:0] longo,
        input logic [3:0] agua
    );
        return (tipo == TIPO_CURTO)  ? curto  :
               (tipo == TIPO_NORMAL) ? normal :
               (tipo == TIPO_LONGO)  ? longo  : agua;
    endfunction

endpackage

// File: rtl/controlador_preparacao_temporizador.sv
// temporizador_dose: loadable 4-bit down-counter that stops at zero
module temporizador_dose (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       carga,
    input  logic       habilita,
    input  logic [3:0] valor,
    output logic       zero
);

    logic [3:0] contagem;

    // load has priority; counting stops once zero is reached
    always_ff @(posedge Clock) begin
        if (Reset)
            contagem <= '0;
        else if (carga)
            contagem <= valor;
        else if (habilita && contagem != 4'd0)
            contagem <= contagem - 4'd1;
    end

    assign zero = (contagem == 4'd0);

endmodule

// File: rtl/controlador_preparacao.sv
// controlador_preparacao: drink preparation sequencer (verify, heat, extract, finish)
module controlador_preparacao
    import controlador_preparacao_pkg::*;
#(
    parameter int TEMPO_AQUECE = TEMPO_AQUECE_PADRAO,
    parameter int DOSE_CURTO   = DOSE_CURTO_PADRAO,
    parameter int DOSE_NORMAL  = DOSE_NORMAL_PADRAO,
    parameter int DOSE_LONGO   = DOSE_LONGO_PADRAO,
    parameter int DOSE_AGUA    = DOSE_AGUA_PADRAO
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Pedido,
    input  logic [1:0] Tipo,
    input  logic       TemAgua,
    input  logic [3:0] TempoDeAgua,
    input  logic       HouveRefill,
    output logic       Usar,
    output logic       Ocupado,
    output logic       Pronto,
    output logic       ErroSemAgua,
    output logic [2:0] Estado,
    output logic [7:0] CafesServidos
);

    estado_t    estado, proximo;
    logic [3:0] dose;
    logic [3:0] valor;
    logic       carga, habilita, zero;

    // the timer is loaded with length-1 so that zero marks the last cycle of a phase
    temporizador_dose u_temporizador (
        .Clock   (Clock),
        .Reset   (Reset),
        .carga   (carga),
        .habilita(habilita),
        .valor   (valor),
        .zero    (zero)
    );

    // state register, registered draw request, latched dose and saturating drink count
    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado        <= IDLE;
            Usar          <= 1'b0;
            dose          <= '0;
            CafesServidos <= '0;
        end else begin
            estado <= proximo;
            Usar   <= (proximo == EXTRAI);
            if (estado == IDLE && Pedido)
                dose <= seleciona_dose(Tipo, 4'(DOSE_CURTO), 4'(DOSE_NORMAL),
                                       4'(DOSE_LONGO), 4'(DOSE_AGUA));
            if (estado == EXTRAI && proximo == CONCLUI && CafesServidos != 8'hFF)
                CafesServidos <= CafesServidos + 8'd1;
        end
    end

    // next state and timer control; a finished draw wins over a simultaneous empty reservoir
    always_comb begin
        proximo  = estado;
        carga    = 1'b0;
        habilita = 1'b0;
        valor    = 4'(TEMPO_AQUECE - 1);
        case (estado)
            IDLE:     proximo = Pedido ? VERIFICA : IDLE;
            VERIFICA: begin
                carga   = TemAgua && TempoDeAgua >= dose;
                proximo = carga ? AQUECE : ERRO;
            end
            AQUECE:   begin
                habilita = 1'b1;
                carga    = zero;
                valor    = dose - 4'd1;
                proximo  = zero ? EXTRAI : AQUECE;
            end
            EXTRAI:   begin
                habilita = 1'b1;
                proximo  = zero ? CONCLUI : (!TemAgua ? ERRO : EXTRAI);
            end
            CONCLUI:  proximo = IDLE;
            ERRO:     proximo = HouveRefill ? IDLE : ERRO;
            default:  proximo = IDLE;
        endcase
    end

    assign Estado      = estado;
    assign Ocupado     = (estado != IDLE);
    assign Pronto      = (estado == CONCLUI);
    assign ErroSemAgua = (estado == ERRO);

endmodule

// File: tb/tb_controlador_preparacao.sv
// tb_controlador_preparacao: vector table, corner sequences and random run against a phase model
module tb_controlador_preparacao;

    localparam int T = 3;

    logic       Clock = 1'b0;
    logic       Reset, Pedido, TemAgua, HouveRefill;
    logic [1:0] Tipo;
    logic [3:0] TempoDeAgua;
    logic       Usar, Ocupado, Pronto, ErroSemAgua;
    logic [2:0] Estado;
    logic [7:0] CafesServidos;

    int total = 0;
    int passou = 0;

    // model: a drink is a phase index t counted from acceptance
    bit m_ativo = 0;
    bit m_erro = 0;
    int m_t = 0;
    int m_dose = 0;
    int m_cafes = 0;

    typedef struct {
        logic       rst, ped;
        logic [1:0] tipo;
        logic       agua;
        logic [3:0] tempo;
        logic       refill;
        logic [2:0] e_est;
        logic       e_usar, e_pronto;
        logic [7:0] e_cafes;
    } vec_t;

    vec_t tab[15];

    controlador_preparacao dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Pedido       (Pedido),
        .Tipo         (Tipo),
        .TemAgua      (TemAgua),
        .TempoDeAgua  (TempoDeAgua),
        .HouveRefill  (HouveRefill),
        .Usar         (Usar),
        .Ocupado      (Ocupado),
        .Pronto       (Pronto),
        .ErroSemAgua  (ErroSemAgua),
        .Estado       (Estado),
        .CafesServidos(CafesServidos)
    );

    always #5 Clock = ~Clock;

    function automatic int dose_de(input logic [1:0] t);
        return (t == 2'd0) ? 2 : (t == 2'd1) ? 4 : (t == 2'd2) ? 6 : 8;
    endfunction

    function automatic int m_estado();
        if (m_erro) return 5;
        if (!m_ativo) return 0;
        if (m_t == 0) return 1;
        if (m_t <= T) return 2;
        if (m_t <= T + m_dose) return 3;
        return 4;
    endfunction

    task modelo_avanca();
        if (Reset) begin
            m_ativo = 0; m_erro = 0; m_cafes = 0;
        end else if (m_erro) begin
            if (HouveRefill) m_erro = 0;
        end else if (!m_ativo) begin
            if (Pedido) begin m_ativo = 1; m_t = 0; m_dose = dose_de(Tipo); end
        end else if (m_t == 0) begin
            if (TemAgua && int'(TempoDeAgua) >= m_dose) m_t = 1;
            else begin m_ativo = 0; m_erro = 1; end
        end else if (m_t <= T) begin
            m_t++;
        end else if (m_t <= T + m_dose) begin
            if (m_t == T + m_dose) begin
                m_t++;
                if (m_cafes < 255) m_cafes++;
            end else if (!TemAgua) begin
                m_ativo = 0; m_erro = 1;
            end else m_t++;
        end else m_ativo = 0;
    endtask

    task chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passou++;
        else $display("FAIL %s: got %0h, expected %0h", nome, act, exp);
    endtask

    task step();
        int e;
        modelo_avanca();
        @(posedge Clock);
        #1;
        e = m_estado();
        chk("modelo", {17'd0, Estado, Usar, Pronto, ErroSemAgua, Ocupado, CafesServidos},
            {17'd0, 3'(e), e == 3, e == 4, m_erro, e != 0, 8'(m_cafes)});
    endtask

    task ocioso();
        Reset = 0; Pedido = 0; Tipo = 2'd0; TemAgua = 1; TempoDeAgua = 4'd15; HouveRefill = 0;
    endtask

    task reinicia();
        Reset = 1; step(); Reset = 0;
    endtask

    task espera_usar(input string nome);
        int n = 0;
        while (!Usar && n < 30) begin step(); n++; end
        chk(nome, {31'd0, Usar}, 32'd1);
    endtask

    task espera_idle(input string nome);
        int n = 0;
        while (Estado != 3'd0 && n < 40) begin step(); n++; end
        chk(nome, {29'd0, Estado}, 32'd0);
    endtask

    initial begin
        int n, prontos;
        ocioso();
        // {rst, ped, tipo, agua, tempo, refill, estado, usar, pronto, cafes}
        tab[0]  = '{1, 0, 2'd1, 1, 4'd10, 0, 3'd0, 0, 0, 8'd0};
        tab[1]  = '{0, 1, 2'd1, 1, 4'd10, 0, 3'd1, 0, 0, 8'd0};
        tab[2]  = '{0, 0, 2'd1, 1, 4'd10, 0, 3'd2, 0, 0, 8'd0};
        tab[3]  = '{0, 0, 2'd1, 1, 4'd10, 0, 3'd2, 0, 0, 8'd0};
        tab[4]  = '{0, 0, 2'd1, 1, 4'd10, 0, 3'd2, 0, 0, 8'd0};
        tab[5]  = '{0, 0, 2'd1, 1, 4'd10, 0, 3'd3, 1, 0, 8'd0};
        tab[6]  = '{0, 0, 2'd1, 1, 4'd10, 0, 3'd3, 1, 0, 8'd0};
        tab[7]  = '{0, 0, 2'd1, 1, 4'd10, 0, 3'd3, 1, 0, 8'd0};
        tab[8]  = '{0, 0, 2'd1, 1, 4'd10, 0, 3'd3, 1, 0, 8'd0};
        tab[9]  = '{0, 0, 2'd1, 1, 4'd10, 0, 3'd4, 0, 1, 8'd1};
        tab[10] = '{0, 0, 2'd1, 1, 4'd10, 0, 3'd0, 0, 0, 8'd1};
        tab[11] = '{0, 1, 2'd2, 1, 4'd5,  0, 3'd1, 0, 0, 8'd1};
        tab[12] = '{0, 0, 2'd2, 1, 4'd5,  0, 3'd5, 0, 0, 8'd1};
        tab[13] = '{0, 0, 2'd2, 1, 4'd5,  0, 3'd5, 0, 0, 8'd1};
        tab[14] = '{0, 0, 2'd2, 1, 4'd5,  1, 3'd0, 0, 0, 8'd1};
        for (int i = 0; i < 15; i++) begin
            Reset = tab[i].rst; Pedido = tab[i].ped; Tipo = tab[i].tipo;
            TemAgua = tab[i].agua; TempoDeAgua = tab[i].tempo; HouveRefill = tab[i].refill;
            step();
            chk($sformatf("tabela[%0d]", i), {19'd0, Estado, Usar, Pronto, CafesServidos},
                {19'd0, tab[i].e_est, tab[i].e_usar, tab[i].e_pronto, tab[i].e_cafes});
        end

        // hot water with the reservoir running dry mid-draw, then refill racing a request
        ocioso(); reinicia();
        Pedido = 1; Tipo = 2'd3; step(); Pedido = 0;
        espera_usar("agua_inicio");
        step(); step(); step();
        TemAgua = 0; step();
        chk("seco_erro", {24'd0, Estado, Usar, Pronto, ErroSemAgua, CafesServidos[1:0]},
            {24'd0, 3'd5, 1'b0, 1'b0, 1'b1, 2'd0});
        TemAgua = 1; HouveRefill = 1; Pedido = 1; step();
        chk("refill_idle", {29'd0, Estado}, 32'd0);
        HouveRefill = 0; Pedido = 0; step();
        chk("pedido_descartado", {29'd0, Estado}, 32'd0);

        // reset in the second extraction cycle, overriding a pending request
        Pedido = 1; Tipo = 2'd1; step(); Pedido = 0;
        espera_idle("bebida_1");
        chk("contagem_1", {24'd0, CafesServidos}, 32'd1);
        Pedido = 1; step(); Pedido = 0;
        espera_usar("normal_inicio");
        step();
        Reset = 1; Pedido = 1; step(); Reset = 0; Pedido = 0;
        chk("reset_meio", {20'd0, Estado, Usar, CafesServidos}, 32'd0);

        // request held high through 256+ short drinks; Tipo toggled while busy must not matter
        Pedido = 1; n = 0;
        while (CafesServidos != 8'hFF && n < 4000) begin
            Tipo = (Estado == 3'd2 || Estado == 3'd3) ? 2'd3 : 2'd0;
            step(); n++;
        end
        chk("satura_255", {24'd0, CafesServidos}, 32'd255);
        prontos = 0;
        for (int i = 0; i < 24; i++) begin
            Tipo = (Estado == 3'd2) ? 2'd2 : 2'd0;
            step();
            if (Pronto) prontos++;
        end
        chk("satura_mantem", {24'd0, CafesServidos}, 32'd255);
        chk("prontos_apos_saturar", 32'(prontos), 32'd3);
        Pedido = 0;
        espera_idle("fim_bebidas");

        // random traffic against the phase model
        for (int i = 0; i < 1500; i++) begin
            Reset = ($urandom_range(0, 99) == 0);
            Pedido = $urandom_range(0, 1);
            Tipo = 2'($urandom_range(0, 3));
            TemAgua = ($urandom_range(0, 9) != 0);
            TempoDeAgua = 4'($urandom_range(0, 15));
            HouveRefill = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passou, total);
        $finish;
    end

endmodule

// File: doc/controlador_preparacao.md
CONTROLADOR_PREPARACAO -- requirements
Module: controlador_preparacao

Interface
REQ-001 SHALL have parameter TEMPO_AQUECE, default 3, heating cycles before extraction (1..15).
REQ-002 SHALL have parameter DOSE_CURTO, default 2, water cycles for Tipo=00.
REQ-003 SHALL have parameter DOSE_NORMAL, default 4, water cycles for Tipo=01.
REQ-004 SHALL have parameter DOSE_LONGO, default 6, water cycles for Tipo=10.
REQ-005 SHALL have parameter DOSE_AGUA, default 8, water cycles for Tipo=11 (hot water).
REQ-006 SHALL use a single clock and a synchronous, active-high reset; all state changes on the rising edge of Clock.
REQ-007 Clock  input  1  system clock.
REQ-008 Reset  input  1  synchronous active-high reset.
REQ-009 Pedido  input  1  drink request, sampled only in IDLE.
REQ-010 Tipo  input  2  drink type, latched with an accepted Pedido.
REQ-011 TemAgua  input  1  reservoir non-empty flag.
REQ-012 TempoDeAgua  input  4  reservoir water remaining, in cycles.
REQ-013 HouveRefill  input  1  reservoir refill indication.
REQ-014 Usar  output  1  registered water draw request to the reservoir.
REQ-015 Ocupado  output  1  high in every state except IDLE.
REQ-016 Pronto  output  1  one-cycle drink-complete pulse.
REQ-017 ErroSemAgua  output  1  high while in ERRO.
REQ-018 Estado  output  3  current state encoding.
REQ-019 CafesServidos  output  8  count of completed drinks.

Function
REQ-020 SHALL implement the states IDLE=0, VERIFICA=1, AQUECE=2, EXTRAI=3, CONCLUI=4, ERRO=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-021 In IDLE, Pedido=1 at edge k SHALL latch the dose selected by Tipo and enter VERIFICA at edge k.
REQ-022 In VERIFICA, TempoDeAgua >= dose and TemAgua=1 SHALL lead to AQUECE; otherwise the block SHALL go to ERRO; the decision takes one cycle.
REQ-023 AQUECE SHALL last exactly TEMPO_AQUECE cycles, timed by a down-counter, then go to EXTRAI.
REQ-024 Usar SHALL rise at edge k+1+TEMPO_AQUECE and stay high for exactly dose cycles. It is high only in EXTRAI.
REQ-025 At the end of EXTRAI the block SHALL enter CONCLUI, drop Usar at that same edge and assert Pronto for exactly one cycle, then return to IDLE.
REQ-026 CafesServidos SHALL increment on entry to CONCLUI and saturate at 255; it does not wrap.
REQ-027 In EXTRAI, a sampled TemAgua=0 with draw cycles remaining SHALL send the block to ERRO at that edge. Usar drops at that edge, with no Pronto and no count.
REQ-028 In ERRO, Usar=0 and ErroSemAgua=1; HouveRefill=1 sampled at an edge SHALL return the block to IDLE.
REQ-029 Pedido while Ocupado=1 SHALL be ignored and not queued; Tipo changes after acceptance SHALL have no effect.
REQ-030 If HouveRefill and Pedido occur in the same ERRO cycle, the block SHALL go to IDLE only; the Pedido is dropped.
REQ-031 Pedido held high continuously SHALL start a new drink on the first IDLE cycle after CONCLUI or ERRO.

Reset
REQ-032 Reset=1 at an edge SHALL force IDLE, Usar=0, Pronto=0, ErroSemAgua=0, CafesServidos=0, and clear all counters, from any state including mid-EXTRAI.
REQ-033 Reset SHALL override Pedido and HouveRefill in the same cycle.

Structure
REQ-034 A shared package SHALL hold the state encodings, the Tipo codes and the default dose and heating constants.
REQ-035 Heating and extraction timing SHALL use one sub-module, temporizador_dose: a loadable 4-bit down-counter with load, enable and zero flag.

Verification
REQ-036 Reset; Pedido=1 at edge 0, Tipo=01, TempoDeAgua=10, TemAgua=1 -> Usar high edges 4..8 (4 cycles), Pronto high edge 8 only, CafesServidos=1.
REQ-037 Tipo=10, TempoDeAgua=5 -> ERRO after VERIFICA, Usar never high; HouveRefill pulse -> IDLE next edge.
REQ-038 Tipo=11, TemAgua forced 0 after 3 Usar cycles -> ERRO at that edge, Usar=0, no Pronto, count unchanged.
REQ-039 Reset asserted during the second EXTRAI cycle -> next edge IDLE, Usar=0, CafesServidos=0.
REQ-040 Pedido held high across 256 short drinks -> CafesServidos saturates at 255; second Pedido during AQUECE is ignored.
